fp32_mul_seq: RTL and testbench

Sequential IEEE-754 single-precision multiplier. It is the companion to the team's iterative FP32 divider and shares the same start/done operand handshake, so datapath control drives both blocks the same way. Mantissas are multiplied by a radix-2 shift-add loop of 24 iterations. The block then normalizes, rounds and packs the result, and handles the special cases: zero, infinity and NaN. Subnormal inputs are treated as zero (DAZ) and subnormal results are flushed to zero (FTZ).

---
 rtl/fp32_mul_seq_if.sv | 24 ++
 rtl/fp32_mul_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_fp32_mul_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_mul_seq_if.sv
// Operand/result handshake bundle for fp32_mul_seq.
// master: drives start, a, b; observes busy, done, result and the flags.
// slave : the multiplier side of the same signals.
interface fp32_mul_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        invalid;
    logic        overflow;
    logic        underflow;

    modport master (
        output start, a, b,
        input  busy, done, result, invalid, overflow, underflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, invalid, overflow, underflow
    );
endinterface

// File: rtl/fp32_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier (DAZ inputs, FTZ results).
// Radix-2 shift-add mantissa multiply over 24 cycles, then normalize/round/pack.
// Ports: clk, rst (async, active-high), bus (fp32_mul_seq_if.slave):
//   start/a/b in; busy, done, result, invalid, overflow, underflow out (registered).
// Option macro: FP32_MUL_RNE_EN -> round to nearest even; undefined -> truncate.
module fp32_mul_seq (
    input  logic          clk,
    input  logic          rst,
    fp32_mul_seq_if.slave bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned FW = 23;
    localparam int unsigned MW = FW + 1;
    localparam int unsigned PW = 2 * MW;
    localparam int unsigned EW = 10;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0]        LAST_ITER = CW'(MW - 1);
    localparam logic signed [EW-1:0] BIAS      = EW'(127);
    localparam logic signed [EW-1:0] EXP_INF   = EW'(255);
    localparam logic [DW-1:0]        QNAN      = 32'h7FC0_0000;

    // DONE holds busy for the done cycle so a start there is not yet accepted
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CALC, S_SPECIAL, S_ROUND, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]        opa_q, opb_q;
    logic                 sign_q;
    logic signed [EW-1:0] exp_q;
    logic [MW-1:0]        ma_q;
    logic [PW-1:0]        p_q;
    logic [CW-1:0]        cnt_q;
    logic [DW-1:0]        sp_res_q;
    logic                 sp_inv_q;

    logic                 busy_q, done_q, invalid_q, overflow_q, underflow_q;
    logic [DW-1:0]        result_q;
    logic                 busy_d, done_d, invalid_d, overflow_d, underflow_d;
    logic [DW-1:0]        result_d;

    // Operand classification and special-case result, priority NaN > inf*0 > inf > zero
    logic [7:0]    ea, eb;
    logic [FW-1:0] fa, fb;
    logic          zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic          sign_c, is_special;
    logic [DW-1:0] sp_res_c;
    logic          sp_inv_c;

    always_comb begin
        ea         = opa_q[30:23];
        eb         = opb_q[30:23];
        fa         = opa_q[FW-1:0];
        fb         = opb_q[FW-1:0];
        zero_a     = (ea == 8'd0);
        zero_b     = (eb == 8'd0);
        inf_a      = (ea == 8'hFF) && (fa == '0);
        inf_b      = (eb == 8'hFF) && (fb == '0);
        nan_a      = (ea == 8'hFF) && (fa != '0);
        nan_b      = (eb == 8'hFF) && (fb != '0);
        sign_c     = opa_q[31] ^ opb_q[31];
        is_special = zero_a | zero_b | inf_a | inf_b | nan_a | nan_b;
        sp_inv_c   = 1'b0;
        sp_res_c   = {sign_c, 31'd0};
        if (nan_a | nan_b) begin
            sp_res_c = QNAN;
            sp_inv_c = 1'b1;
        end else if ((inf_a & zero_b) | (zero_a & inf_b)) begin
            sp_res_c = QNAN;
            sp_inv_c = 1'b1;
        end else if (inf_a | inf_b) begin
            sp_res_c = {sign_c, 8'hFF, 23'd0};
        end
    end

    // One shift-add step: multiplier bits live in the low half of p
    logic [MW:0] sum_c;
    always_comb begin
        sum_c = {1'b0, p_q[PW-1:MW]} + (p_q[0] ? {1'b0, ma_q} : '0);
    end

    // Normalize and round
    logic                 hi;
    logic signed [EW-1:0] exp_n, exp_r;
    logic [FW-1:0]        frac_t, frac_r;
`ifdef FP32_MUL_RNE_EN
    logic          guard, sticky;
    logic [MW-1:0] frac_inc;
`endif

    always_comb begin
        hi     = p_q[PW-1];
        exp_n  = exp_q + $signed({{(EW-1){1'b0}}, hi});
        frac_t = hi ? p_q[PW-2 -: FW] : p_q[PW-3 -: FW];
`ifdef FP32_MUL_RNE_EN
        guard    = hi ? p_q[MW-1] : p_q[MW-2];
        sticky   = hi ? (|p_q[MW-2:0]) : (|p_q[MW-3:0]);
        frac_inc = {1'b0, frac_t} + MW'(guard & (sticky | frac_t[0]));
        frac_r   = frac_inc[FW] ? '0 : frac_inc[FW-1:0];
        exp_r    = exp_n + $signed({{(EW-1){1'b0}}, frac_inc[FW]});
`else
        frac_r   = frac_t;
        exp_r    = exp_n;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (bus.start) state_d = S_LOAD;
            S_LOAD:    state_d = is_special ? S_SPECIAL : S_CALC;
            S_CALC:    if (cnt_q == LAST_ITER) state_d = S_ROUND;
            S_SPECIAL: state_d = S_DONE;
            S_ROUND:   state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output next values; result and flags hold between completions
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = 1'b0;
        result_d    = result_q;
        invalid_d   = invalid_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        unique case (state_q)
            S_SPECIAL: begin
                done_d      = 1'b1;
                result_d    = sp_res_q;
                invalid_d   = sp_inv_q;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            S_ROUND: begin
                done_d      = 1'b1;
                invalid_d   = 1'b0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
                if (exp_r >= EXP_INF) begin
                    result_d   = {sign_q, 8'hFF, 23'd0};
                    overflow_d = 1'b1;
                end else if (exp_r <= $signed(EW'(0))) begin
                    result_d    = {sign_q, 31'd0};
                    underflow_d = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r[7:0], frac_r};
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            invalid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            invalid_q   <= invalid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Datapath: operand capture, unpack, iterative multiply
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q    <= '0;
            opb_q    <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            ma_q     <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            sp_res_q <= '0;
            sp_inv_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (bus.start) begin
                    opa_q <= bus.a;
                    opb_q <= bus.b;
                end
                S_LOAD: begin
                    sign_q   <= sign_c;
                    exp_q    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                    ma_q     <= {1'b1, fa};
                    p_q      <= {{MW{1'b0}}, 1'b1, fb};
                    cnt_q    <= '0;
                    sp_res_q <= sp_res_c;
                    sp_inv_q <= sp_inv_c;
                end
                S_CALC: begin
                    p_q   <= {sum_c, p_q[MW-1:1]};
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.invalid   = invalid_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fp32_mul_seq.sv
// Testbench for fp32_mul_seq: directed vectors plus randomized operands checked
// against an integer-arithmetic reference model. Honors FP32_MUL_RNE_EN.
module tb_fp32_mul_seq;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fp32_mul_seq_if bus ();

    fp32_mul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise start and count edges until busy is seen (1 when idle, 2 from a done cycle)
    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int waited);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        waited    = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy) begin
                waited = k;
                break;
            end
        end
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic einv, input logic eovf,
                          input logic eunf, input int elat, input int ewait, input int poke_at);
        int waited;
        int lat;
        bit busy_drop;
        issue(a, b, waited);
        check({tag, "/accept"}, 32'(waited), 32'(ewait));
        lat       = 0;
        busy_drop = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == poke_at) begin
                bus.start = 1'b1;
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (!bus.busy) busy_drop = 1'b1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check({tag, "/latency"}, 32'(lat), 32'(elat));
        check({tag, "/busy_held"}, 32'(busy_drop), 32'd0);
        check({tag, "/result"}, bus.result, er);
        check({tag, "/invalid"}, 32'(bus.invalid), 32'(einv));
        check({tag, "/overflow"}, 32'(bus.overflow), 32'(eovf));
        check({tag, "/underflow"}, 32'(bus.underflow), 32'(eunf));
    endtask

    // Reference: exact integer product, then arithmetic normalize/round by remainder
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic inv,
                                  output logic ovf, output logic unf, output int lat);
        bit s;
        int ea, eb, e, sh;
        bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        longint unsigned ma, mb, prod, q;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        nan_a  = (ea == 255) && (a[22:0] != 0);
        nan_b  = (eb == 255) && (b[22:0] != 0);
        inf_a  = (ea == 255) && (a[22:0] == 0);
        inf_b  = (eb == 255) && (b[22:0] == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        r = 32'd0; inv = 1'b0; ovf = 1'b0; unf = 1'b0; lat = 2;
        if (nan_a || nan_b) begin
            r = 32'h7FC00000; inv = 1'b1;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            r = 32'h7FC00000; inv = 1'b1;
        end else if (inf_a || inf_b) begin
            r = {s, 8'hFF, 23'h0};
        end else if (zero_a || zero_b) begin
            r = {s, 31'h0};
        end else begin
            lat  = 26;
            ma   = 64'(a[22:0]) + (64'd1 << 23);
            mb   = 64'(b[22:0]) + (64'd1 << 23);
            prod = ma * mb;
            e    = ea + eb - 127;
            if (prod >= (64'd1 << 47)) begin
                sh = 24;
                e  = e + 1;
            end else begin
                sh = 23;
            end
            q = prod >> sh;
`ifdef FP32_MUL_RNE_EN
            begin
                longint unsigned rem, half;
                rem  = prod - (q << sh);
                half = 64'd1 << (sh - 1);
                if (rem > half || (rem == half && q[0] == 1'b1)) q = q + 1;
                if (q == (64'd1 << 24)) begin
                    q = 64'd1 << 23;
                    e = e + 1;
                end
            end
`endif
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0}; ovf = 1'b1;
            end else if (e <= 0) begin
                r = {s, 31'h0}; unf = 1'b1;
            end else begin
                r = {s, 8'(e), 23'(q)};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: ;
            1: case ($urandom_range(0, 5))
                   0: v = 32'h0000_0000;
                   1: v = 32'h8000_0000;
                   2: v = {v[31], 8'hFF, 23'h0};
                   3: v = 32'h7FC0_0000;
                   4: v = {v[31], 8'hFF, 23'h1};
                   default: v = v & 32'h807F_FFFF;
               endcase
            default: v = {v[31], 8'($urandom_range(40, 214)), v[22:0]};
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] ra, rb, er;
        logic einv, eovf, eunf;
        int elat, gap;
        bit saw_done;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        idle(3);
        check("reset/busy", 32'(bus.busy), 32'd0);
        check("reset/done", 32'(bus.done), 32'd0);
        check("reset/result", bus.result, 32'd0);
        check("reset/invalid", 32'(bus.invalid), 32'd0);
        check("reset/overflow", 32'(bus.overflow), 32'd0);
        check("reset/underflow", 32'(bus.underflow), 32'd0);
        rst = 1'b0;
        idle(1);

        run_op("3x2.5", 32'h40400000, 32'h40200000, 32'h40F00000, 0, 0, 0, 26, 1, 0);
        idle(1);
        check("done_pulse", 32'(bus.done), 32'd0);
        check("done_hold_result", bus.result, 32'h40F00000);

        run_op("1.5x-1.5", 32'h3FC00000, 32'hBFC00000, 32'hC0100000, 0, 0, 0, 26, 1, 0);
        run_op("b2b_1x1", 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 0, 26, 2, 0);
        idle(1);

        run_op("inf_x_0", 32'h7F800000, 32'h00000000, 32'h7FC00000, 1, 0, 0, 2, 1, 0);
        run_op("daz_b2b", 32'h00400000, 32'h40000000, 32'h00000000, 0, 0, 0, 2, 2, 0);
        idle(1);

        run_op("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 0, 1, 0, 26, 1, 0);
        idle(1);
        run_op("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 0, 0, 1, 26, 1, 0);
        idle(1);
`ifdef FP32_MUL_RNE_EN
        run_op("round", 32'h3FC00001, 32'h3FC00001, 32'h40100002, 0, 0, 0, 26, 1, 0);
`else
        run_op("round", 32'h3FC00001, 32'h3FC00001, 32'h40100001, 0, 0, 0, 26, 1, 0);
`endif
        idle(1);

        run_op("start_while_busy", 32'h3FC00000, 32'hBFC00000, 32'hC0100000, 0, 0, 0, 26, 1, 5);
        idle(1);

        // Abort an operation with reset at cycle 10
        issue(32'h40400000, 32'h40200000, elat);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort/busy", 32'(bus.busy), 32'd0);
        check("abort/done", 32'(bus.done), 32'd0);
        check("abort/result", bus.result, 32'd0);
        check("abort/flags", {29'd0, bus.invalid, bus.overflow, bus.underflow}, 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) rst = 1'b0;
            if (bus.done) saw_done = 1'b1;
        end
        check("abort/no_done", 32'(saw_done), 32'd0);
        check("abort/idle_busy", 32'(bus.busy), 32'd0);
        run_op("after_abort", 32'h40400000, 32'h40200000, 32'h40F00000, 0, 0, 0, 26, 1, 0);

        for (int i = 0; i < 40; i++) begin
            ra  = rand_op();
            rb  = rand_op();
            gap = $urandom_range(0, 2);
            idle(gap);
            model(ra, rb, er, einv, eovf, eunf, elat);
            run_op($sformatf("rand%0d_%h_%h", i, ra, rb), ra, rb, er, einv, eovf, eunf,
                   elat, (gap == 0) ? 2 : 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
